// File: rtl/fetch_redirect_ctrl.sv
// Front-end next-PC sequencer: chooses the PC source, gates PC updates with fetch
// back-pressure, and drains/redirects the front end after a branch mispredict.
module fetch_redirect_ctrl #(
   parameter int                XLEN         = 32,
   parameter logic [XLEN-1:0]   BOOT_PC      = 32'h0000_0200,
   parameter int                FLUSH_CYCLES = 2,
   parameter int                EPOCH_W      = 2
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               pred_valid_i,
   input  logic               pred_taken_i,
   input  logic [XLEN-1:0]    pred_target_i,
   input  logic               res_valid_i,
   input  logic               res_mispredict_i,
   input  logic               res_taken_i,
   input  logic [XLEN-1:0]    res_target_i,
   input  logic [XLEN-1:0]    res_pc_i,
   input  logic               fetch_ready_i,
   output logic [1:0]         pc_sel_o,
   output logic               pc_en_o,
   output logic [XLEN-1:0]    redir_target_o,
   output logic               fetch_valid_o,
   output logic               flush_o,
   output logic [EPOCH_W-1:0] epoch_o
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

   localparam logic [1:0] SEL_SEQ   = 2'b00;
   localparam logic [1:0] SEL_PRED  = 2'b01;
   localparam logic [1:0] SEL_REDIR = 2'b10;
   localparam logic [1:0] SEL_BOOT  = 2'b11;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_FLUSH
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              mp;
   logic [XLEN-1:0]   mp_target;
   logic [1:0]        sel;
   logic              en;
   logic              fvalid;
   logic              flush;

   // Target and BOOT_PC are consumed by the external PC mux, not here.
   logic unused_ok;
   assign unused_ok = ^{pred_target_i, BOOT_PC};

   assign mp        = res_valid_i & res_mispredict_i;
   assign mp_target = res_taken_i ? res_target_i : res_pc_i + XLEN'(4);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= S_BOOT;
         cnt            <= '0;
         epoch_o        <= '0;
         redir_target_o <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (mp) begin
            redir_target_o <= mp_target;
            epoch_o        <= epoch_o + EPOCH_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sel       = SEL_SEQ;
      en        = 1'b0;
      fvalid    = 1'b0;
      flush     = 1'b0;
      case (state)
         S_BOOT: begin
            sel       = SEL_BOOT;
            en        = 1'b1;
            state_nxt = S_RUN;
         end
         S_RUN: begin
            fvalid = 1'b1;
            if (fetch_ready_i) begin
               en  = 1'b1;
               sel = (pred_valid_i && pred_taken_i) ? SEL_PRED : SEL_SEQ;
            end
         end
         S_FLUSH: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               sel = SEL_REDIR;
               if (fetch_ready_i) begin
                  en        = 1'b1;
                  state_nxt = S_RUN;
               end
            end
         end
         default: state_nxt = S_BOOT;
      endcase
      // A mispredict overrides everything, including a redirect about to issue.
      if (mp) begin
         flush     = 1'b1;
         en        = 1'b0;
         cnt_nxt   = CNT_W'(FLUSH_CYCLES);
         state_nxt = S_FLUSH;
      end
   end

   assign pc_sel_o      = rst_n_i ? sel : SEL_BOOT;
   assign pc_en_o       = en & rst_n_i;
   assign fetch_valid_o = fvalid & rst_n_i;
   assign flush_o       = flush & rst_n_i;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios then random traffic,
// every cycle compared against a cycle-count based reference model.
module tb_fetch_redirect_ctrl;

   localparam int XLEN = 32;
   localparam int FC   = 2;
   localparam int EW   = 2;

   logic            clk_i = 1'b0;
   logic            rst_n_i;
   logic            pred_valid_i, pred_taken_i;
   logic [XLEN-1:0] pred_target_i;
   logic            res_valid_i, res_mispredict_i, res_taken_i;
   logic [XLEN-1:0] res_target_i, res_pc_i;
   logic            fetch_ready_i;
   logic [1:0]      pc_sel_o;
   logic            pc_en_o;
   logic [XLEN-1:0] redir_target_o;
   logic            fetch_valid_o;
   logic            flush_o;
   logic [EW-1:0]   epoch_o;

   int nVectors     = 0;
   int nMiscompares = 0;

   // Reference model: booted flag, pending redirect and cycles elapsed since the mispredict.
   bit          mBooted;
   bit          mPending;
   int          mSince;
   logic [31:0] mTarget;
   int          mEpoch;

   fetch_redirect_ctrl #(
      .XLEN(XLEN), .BOOT_PC(32'h0000_0200), .FLUSH_CYCLES(FC), .EPOCH_W(EW)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .pred_valid_i(pred_valid_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
      .res_valid_i(res_valid_i), .res_mispredict_i(res_mispredict_i), .res_taken_i(res_taken_i),
      .res_target_i(res_target_i), .res_pc_i(res_pc_i), .fetch_ready_i(fetch_ready_i),
      .pc_sel_o(pc_sel_o), .pc_en_o(pc_en_o), .redir_target_o(redir_target_o),
      .fetch_valid_o(fetch_valid_o), .flush_o(flush_o), .epoch_o(epoch_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVectors++;
      assert (obs === exp) else begin
         nMiscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      mBooted  = 1'b0;
      mPending = 1'b0;
      mSince   = 0;
      mTarget  = 32'h0;
      mEpoch   = 0;
   endtask

   task automatic checkReset(input string tag);
      cmp({tag, "_sel"},   32'(pc_sel_o),       32'd3);
      cmp({tag, "_en"},    32'(pc_en_o),        32'd0);
      cmp({tag, "_fv"},    32'(fetch_valid_o),  32'd0);
      cmp({tag, "_flush"}, 32'(flush_o),        32'd0);
      cmp({tag, "_epoch"}, 32'(epoch_o),        32'd0);
      cmp({tag, "_redir"}, redir_target_o,      32'd0);
   endtask

   task automatic applyStimulus(input logic pv, input logic pt, input logic [31:0] ptgt,
                                input logic rv, input logic rmp, input logic rt,
                                input logic [31:0] rtgt, input logic [31:0] rpc,
                                input logic rdy);
      pred_valid_i     = pv;
      pred_taken_i     = pt;
      pred_target_i    = ptgt;
      res_valid_i      = rv;
      res_mispredict_i = rmp;
      res_taken_i      = rt;
      res_target_i     = rtgt;
      res_pc_i         = rpc;
      fetch_ready_i    = rdy;
   endtask

   task automatic checkOutput();
      logic        mp;
      bit          elig;
      bit          selChk;
      logic [31:0] expEn, expFv, expSel, newTarget;
      logic        rdy;
      @(negedge clk_i);
      mp        = res_valid_i & res_mispredict_i;
      rdy       = fetch_ready_i;
      newTarget = res_taken_i ? res_target_i : res_pc_i + 32'd4;
      elig      = mPending && (mSince >= FC + 1);
      if (!mBooted) begin
         expFv  = 0;
         expEn  = {31'b0, !mp};
         expSel = 3;
         selChk = !mp;
      end else if (mPending) begin
         expFv  = 0;
         expEn  = {31'b0, elig && rdy && !mp};
         expSel = 2;
         selChk = elig;
      end else begin
         expFv  = 1;
         expEn  = {31'b0, rdy && !mp};
         expSel = (pred_valid_i && pred_taken_i) ? 32'd1 : 32'd0;
         selChk = rdy && !mp;
      end
      cmp("pc_en",    32'(pc_en_o),       expEn);
      cmp("fv",       32'(fetch_valid_o), expFv);
      cmp("flush",    32'(flush_o),       {31'b0, mp});
      cmp("epoch",    32'(epoch_o),       32'(mEpoch));
      cmp("redir",    redir_target_o,     mTarget);
      if (selChk) cmp("pc_sel", 32'(pc_sel_o), expSel);
      @(posedge clk_i);
      if (mp) begin
         mTarget  = newTarget;
         mEpoch   = (mEpoch + 1) % (1 << EW);
         mPending = 1'b1;
         mSince   = 1;
         mBooted  = 1'b1;
      end else if (!mBooted) begin
         mBooted = 1'b1;
      end else if (mPending) begin
         if (elig && rdy) mPending = 1'b0;
         else             mSince++;
      end
      #1;
   endtask

   task automatic idle(input logic pv, input logic pt, input logic rdy);
      applyStimulus(pv, pt, $urandom, 1'b0, 1'b0, 1'b0, $urandom, $urandom, rdy);
      checkOutput();
   endtask

   task automatic mispredict(input logic rt, input logic [31:0] tgt, input logic [31:0] pc,
                             input logic rdy);
      applyStimulus(1'b1, 1'b1, $urandom, 1'b1, 1'b1, rt, tgt, pc, rdy);
      checkOutput();
   endtask

   initial begin
      resetModel();
      rst_n_i = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #2;
      checkReset("rst");
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;

      // Boot then sequential fetch
      for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b1);
      // Predicted taken, then a 3-cycle stall
      for (int i = 0; i < 2; i++) idle(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b1, 1'b1, 1'b0);

      // Taken mispredict to 0x1000 with ready high
      mispredict(1'b1, 32'h0000_1000, 32'h0000_0400, 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b1);
      cmp("dir_redir1", redir_target_o, 32'h0000_1000);
      cmp("dir_epoch1", 32'(epoch_o), 32'd1);

      // Not-taken mispredict at the top of the address space, redirect held 4 cycles
      mispredict(1'b0, 32'h0000_5555, 32'hFFFF_FFFC, 1'b1);
      for (int i = 0; i < 2; i++) idle(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b0);
      idle(1'b0, 1'b0, 1'b1);
      idle(1'b0, 1'b0, 1'b1);
      cmp("dir_redir_wrap", redir_target_o, 32'h0000_0000);
      cmp("dir_epoch2", 32'(epoch_o), 32'd2);

      // Mispredict landing exactly when the redirect would issue
      mispredict(1'b1, 32'h0000_1234, 32'h0000_0800, 1'b1);
      cmp("dir_epoch3", 32'(epoch_o), 32'd3);
      for (int i = 0; i < 2; i++) idle(1'b0, 1'b0, 1'b1);
      mispredict(1'b1, 32'h0000_2000, 32'h0000_0900, 1'b1);
      cmp("dir_epoch_wrap", 32'(epoch_o), 32'd0);
      cmp("dir_redir2", redir_target_o, 32'h0000_2000);
      for (int i = 0; i < 4; i++) idle(1'b0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a drain
      mispredict(1'b1, 32'h0000_3000, 32'h0000_0a00, 1'b1);
      idle(1'b0, 1'b0, 1'b1);
      #2;
      applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b1, 1'b1, 32'h0000_4000, 0, 1'b1);
      rst_n_i = 1'b0;
      #1;
      checkReset("midrst");
      resetModel();
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      for (int i = 0; i < 3; i++) idle(1'b0, 1'b0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic        rv, rmp;
         logic [31:0] rpc;
         rv  = ($urandom_range(0, 3) == 0);
         rmp = ($urandom_range(0, 2) == 0);
         rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                       rv, rmp, $urandom_range(0, 1), $urandom, rpc,
                       ($urandom_range(0, 3) != 0));
         checkOutput();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
